pdp8_iobus: RTL

Parametrised PDP-8 I/O bus concentrator that joins the CPU's IOT interface to NDEV peripheral slots and NDMA data-break channels. It muxes per-device IOT responses by fixed priority and flags select conflicts. It latches and masks device interrupts. It arbitrates data-break memory requests round-robin onto the single CPU RAM port. It sits between the CPU core and the peripheral instances (clock, teletype, disk, ...) and generalises the fixed three-device I/O wrapper.

---
 rtl/pdp8_iobus.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/pdp8_iobus.sv
// Purpose: PDP-8 I/O bus concentrator: IOT response mux, interrupt mask, data-break arbiter.
// Latency: IOT responses combinational; io_interrupt 1 cycle; DMA grant 1 cycle, dma_done 1 cycle after io_ram_done.
// Backpressure: channels hold requests until dma_done; RAM port held until io_ram_done. Optional DMA: PDP8_IOBUS_DMA_EN.
module pdp8_iobus #(
    parameter int          NDEV     = 4,
    parameter int          NDMA     = 2,
    parameter logic [5:0]  MASK_DEV = 6'o77
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iot,
    input  logic [11:0]          mb,
    input  logic [5:0]           io_select,
    input  logic [11:0]          io_data_in,
    output logic [11:0]          io_data_out,
    output logic                 io_data_avail,
    output logic                 io_skip,
    output logic                 io_clear_ac,
    output logic                 io_interrupt,
    input  logic [NDEV-1:0]      dev_selected,
    input  logic [NDEV-1:0]      dev_data_avail,
    input  logic [NDEV-1:0]      dev_skip,
    input  logic [NDEV-1:0]      dev_clear_ac,
    input  logic [NDEV-1:0]      dev_interrupt,
    input  logic [12*NDEV-1:0]   dev_data_out,
    output logic                 bus_conflict,
    input  logic [NDMA-1:0]      dma_read_req,
    input  logic [NDMA-1:0]      dma_write_req,
    input  logic [15*NDMA-1:0]   dma_ma,
    input  logic [12*NDMA-1:0]   dma_out,
    output logic [NDMA-1:0]      dma_done,
    output logic [11:0]          dma_in,
    output logic                 io_ram_read_req,
    output logic                 io_ram_write_req,
    output logic [14:0]          io_ram_ma,
    output logic [11:0]          io_ram_out,
    input  logic                 io_ram_done,
    input  logic [11:0]          io_ram_in
);

    logic [NDEV-1:0] mask;
    logic [NDEV-1:0] int_pend;
    logic            iot_q;
    logic            ctl_sel;
    logic            ctl_edge;
    logic            conflict_now;
    logic            unused_bits;

    // The control register answers only while its own device code is strobed;
    // side effects (mask write, conflict clear) happen once, on the iot rising edge.
    assign ctl_sel      = iot && (io_select == MASK_DEV);
    assign ctl_edge     = ctl_sel && !iot_q;
    assign conflict_now = ($countones(dev_selected) > 1);
    assign io_interrupt = |int_pend;
    assign unused_bits  = &{1'b0, mb[11:3], io_data_in};

    // Response mux: lowest selected slot wins; control register overrides all slots.
    always_comb begin
        logic        hit;
        logic [11:0] mask_ext;
        hit           = 1'b0;
        mask_ext      = '0;
        mask_ext[NDEV-1:0] = mask;
        io_data_out   = '0;
        io_data_avail = 1'b0;
        io_skip       = 1'b0;
        io_clear_ac   = 1'b0;
        for (int k = 0; k < NDEV; k++) begin
            if (!hit && dev_selected[k]) begin
                hit           = 1'b1;
                io_data_out   = dev_data_out[12*k +: 12];
                io_data_avail = dev_data_avail[k];
                io_skip       = dev_skip[k];
                io_clear_ac   = dev_clear_ac[k];
            end
        end
        if (ctl_sel) begin
            io_data_out   = mb[2] ? mask_ext : 12'd0;
            io_data_avail = mb[2];
            io_skip       = mb[0] && io_interrupt;
            io_clear_ac   = 1'b0;
        end
    end

    // Mask, interrupt latch and sticky conflict flag; a fresh conflict beats a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            iot_q        <= 1'b0;
            mask         <= '1;
            int_pend     <= '0;
            bus_conflict <= 1'b0;
        end else begin
            iot_q    <= iot;
            int_pend <= dev_interrupt & mask;
            if (ctl_edge && mb[1])
                mask <= io_data_in[NDEV-1:0];
            if (conflict_now)
                bus_conflict <= 1'b1;
            else if (ctl_edge && mb[2])
                bus_conflict <= 1'b0;
        end
    end

`ifdef PDP8_IOBUS_DMA_EN
    localparam int CH_W = (NDMA > 1) ? $clog2(NDMA) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RECOVER = 2'd2
    } dma_state_t;

    dma_state_t      state_q, state_d;
    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] ch_q;
    logic [CH_W-1:0] grant_ch;
    logic            grant_vld;
    logic            rd_q, wr_q;
    logic [14:0]     ma_q;
    logic [11:0]     out_q;
    logic [NDMA-1:0] done_q;
    logic [11:0]     din_q;

    // Round-robin search: first requesting channel at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int i = 0; i < NDMA; i++) begin
            idx = (int'(rr_ptr) + i) % NDMA;
            if (!grant_vld && (dma_read_req[idx] || dma_write_req[idx])) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'(idx);
            end
        end
    end

    // Arbiter next-state: one transfer in flight, one dead cycle between grants.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (grant_vld)   state_d = ST_BUSY;
            ST_BUSY:    if (io_ram_done) state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Transfer datapath: latch the granted channel, drive RAM, return completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            ch_q   <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            ma_q   <= '0;
            out_q  <= '0;
            done_q <= '0;
            din_q  <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld) begin
                        ch_q  <= grant_ch;
                        ma_q  <= dma_ma[15*int'(grant_ch) +: 15];
                        out_q <= dma_out[12*int'(grant_ch) +: 12];
                        rd_q  <= dma_read_req[grant_ch];
                        wr_q  <= !dma_read_req[grant_ch];
                    end
                end
                ST_BUSY: begin
                    if (io_ram_done) begin
                        rd_q         <= 1'b0;
                        wr_q         <= 1'b0;
                        done_q[ch_q] <= 1'b1;
                        din_q        <= io_ram_in;
                        rr_ptr       <= (ch_q == CH_W'(NDMA - 1)) ? '0 : ch_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_ram_read_req  = rd_q;
    assign io_ram_write_req = wr_q;
    assign io_ram_ma        = ma_q;
    assign io_ram_out       = out_q;
    assign dma_done         = done_q;
    assign dma_in           = din_q;
`else
    logic unused_dma;
    assign unused_dma       = &{1'b0, dma_read_req, dma_write_req, dma_ma, dma_out, io_ram_done, io_ram_in};
    assign io_ram_read_req  = 1'b0;
    assign io_ram_write_req = 1'b0;
    assign io_ram_ma        = '0;
    assign io_ram_out       = '0;
    assign dma_done         = '0;
    assign dma_in           = '0;
`endif

endmodule
